fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
// Round-robin write-side arbiter that shares one asynchronous FIFO write port among NUM_REQ requesters.
// Grants one requester at a time for a burst of up to MAX_BURST words.
// Muxes the granted requester's data onto the FIFO write port and throttles on the FIFO full flag.
// Sits entirely in the FIFO write-clock domain.
// PARAMETERS
// NUM_REQ     4                   number of requesters (>=2)
// DATA_WIDTH  4                   word width; matches FIFO DATA_WIDTH
// MAX_BURST   4                   max words per grant (>=1)
// IDX_W       $clog2(NUM_REQ)     width of grant_idx
// PORTS
// w_clk        in   1                    write clock, single clock for the block
// w_rst_n      in   1                    asynchronous active-low reset
// req          in   NUM_REQ              per-requester word available (level)
// req_data     in   NUM_REQ*DATA_WIDTH   packed words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
// req_last     in   NUM_REQ              current word is requester's last of its packet
// req_ready    out  NUM_REQ              word accepted this cycle (transfer strobe)
// fifo_full    in   1                    FIFO full flag (write domain)
// fifo_w_en    out  1                    FIFO write enable
// fifo_w_data  out  DATA_WIDTH           FIFO write data
// grant        out  NUM_REQ              one-hot registered grant, all-zero when idle
// grant_idx    out  IDX_W                index of the current/last granted requester
// busy         out  1                    high in state BURST
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low.
// - Reset (w_rst_n=0, asynchronous): state=IDLE, grant=0, grant_idx=0, burst_cnt=0, rr_last=NUM_REQ-1.
//   Consequences: busy=0, fifo_w_en=0, req_ready=0. After reset, requester 0 has top priority.
// - Transfer: xfer = (grant[g] & req[g] & ~fifo_full), where g = grant_idx.
//   Combinational outputs: fifo_w_en = xfer; req_ready = xfer ? (1<<g) : 0; fifo_w_data = req_data slice g.
//   fifo_w_data drives slice g even when xfer=0.
// - Arbitration (combinational): winner = first i with req[i]=1, scanning rr_last+1, rr_last+2, ... modulo NUM_REQ.
//   The just-served requester has lowest priority.
// - FSM IDLE: if |req, next state is BURST with grant=onehot(winner), grant_idx=winner, rr_last=winner, burst_cnt=0.
//   Otherwise stay IDLE.
// - FSM BURST end condition: end = (xfer & req_last[g]) | (xfer & burst_cnt==MAX_BURST-1) | ~req[g].
//   On xfer without end: burst_cnt += 1.
//   On end with |req: re-arbitrate the same cycle. Next cycle is BURST with the new winner and burst_cnt=0 (zero-bubble handover).
//   The ending requester can re-win only if it is the sole requester.
//   On end with no req: go IDLE, grant=0 (grant_idx holds).
// - fifo_full in BURST: no transfer, burst_cnt holds, grant held indefinitely.
//   There is no timeout; a req drop during full still releases the grant.
// - Latency: req rises in IDLE -> grant next edge -> first write in that cycle if not full. A single requester gets 1 idle cycle only at start.
// - burst_cnt width $clog2(MAX_BURST+1); it never exceeds MAX_BURST-1.
// - req_data/req_last are sampled only when xfer=1; requesters must hold them stable while req=1 and no req_ready.
// - Reset mid-burst: immediate release (grant=0, fifo_w_en=0). Words already written stay in the FIFO; no partial-burst recovery.
// TESTING
// 1 Reset: w_rst_n=0 mid-burst -> grant=0, fifo_w_en=0 before the next edge; after release req=4'b1111 -> first grant=4'b0001.
// 2 req[1] only, 6 words, last on word 6, MAX_BURST=4 -> 4 writes; handover to 1 with no gap; 2 writes; then IDLE, grant=0.
// 3 req=4'b1111 held, never last, never full -> grant order 0,1,2,3,0; fifo_w_en high 16 consecutive cycles; data order verified.
// 4 fifo_full=1 for 3 cycles after word 2 of a burst -> fifo_w_en=0 and req_ready=0 for 3 cycles; exactly 4 words written in total.
// 5 req_last on first word of requester 2, req[3] pending -> 1-word burst; grant=4'b1000 next cycle.
// 6 Granted req[0] drops before any write, req[2] high -> no write that cycle; grant=4'b0100 next cycle.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Rev 1.0
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 4,
   parameter int MAX_BURST  = 4,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          w_clk,
   input  logic                          w_rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic [IDX_W-1:0]              grant_idx,
   output logic                          busy
);

   localparam int               CNT_W    = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]   rr_last_q, rr_last_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic [IDX_W-1:0]   win_idx;
   logic               win_vld;
   logic               xfer;
   logic               burst_end;

   // Scan starts just after the last winner, so the requester just served is checked last.
   always_comb begin
      int scan;
      win_vld = 1'b0;
      win_idx = '0;
      scan    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan = (int'(rr_last_q) + k) % NUM_REQ;
         if (!win_vld && req[IDX_W'(scan)]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(scan);
         end
      end
   end

   assign xfer      = grant_q[grant_idx_q] & req[grant_idx_q] & ~fifo_full;
   assign burst_end = (xfer & (req_last[grant_idx_q] | (burst_cnt_q == CNT_LAST)))
                    | ~req[grant_idx_q];

   always_comb begin
      fifo_w_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx_q == IDX_W'(i)) begin
            fifo_w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign fifo_w_en = xfer;
   assign req_ready = xfer ? grant_q : '0;
   assign grant     = grant_q;
   assign grant_idx = grant_idx_q;
   assign busy      = (state_q == S_BURST);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      rr_last_d   = rr_last_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d     = S_BURST;
               grant_d     = NUM_REQ'(1) << win_idx;
               grant_idx_d = win_idx;
               rr_last_d   = win_idx;
               burst_cnt_d = '0;
            end
         end
         S_BURST: begin
            if (burst_end) begin
               // Handover happens in the same cycle so the next burst starts without a bubble.
               if (win_vld) begin
                  grant_d     = NUM_REQ'(1) << win_idx;
                  grant_idx_d = win_idx;
                  rr_last_d   = win_idx;
                  burst_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
                  grant_d = '0;
               end
            end else if (xfer) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         grant_idx_q <= '0;
         rr_last_q   <= IDX_LAST;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         rr_last_q   <= rr_last_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// tb_fifo_write_arbiter: vector table, directed corner sequences and random traffic vs. a reference model.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int MB = 4;

   logic            w_clk     = 1'b0;
   logic            w_rst_n   = 1'b0;
   logic [N-1:0]    req       = '0;
   logic [N*DW-1:0] req_data  = '0;
   logic [N-1:0]    req_last  = '0;
   logic            fifo_full = 1'b0;
   logic [N-1:0]    req_ready;
   logic            fifo_w_en;
   logic [DW-1:0]   fifo_w_data;
   logic [N-1:0]    grant;
   logic [1:0]      grant_idx;
   logic            busy;

   fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .req         (req),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_w_en   (fifo_w_en),
      .fifo_w_data (fifo_w_data),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .busy        (busy)
   );

   always #5 w_clk = ~w_clk;

   int errs   = 0;
   int checks = 0;

   // Reference model: who owns the port, how many words it has delivered, who was served last.
   bit m_busy;
   int m_g, m_words, m_rr;

   logic [N-1:0]  s_grant, s_ready;
   logic [DW-1:0] s_data;
   logic [1:0]    s_idx;
   logic          s_wen, s_busy;
   int            sent[N];

   typedef struct {
      logic [N-1:0]  req;
      logic [N-1:0]  last;
      logic          full;
      logic [N-1:0]  grant;
      logic [1:0]    idx;
      logic          wen;
      logic [N-1:0]  ready;
      logic [DW-1:0] data;
      logic          busy;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int pick(input int rr, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         if (r[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_busy  = 1'b0;
      m_g     = 0;
      m_words = 0;
      m_rr    = N - 1;
   endtask

   // One clock: compare DUT against the model mid-cycle, then advance the model across the edge.
   task automatic cycle();
      bit            x, ended;
      int            g, w, done;
      logic [N-1:0]  e_grant, e_ready;
      logic [DW-1:0] e_data;
      @(negedge w_clk);
      g       = m_g;
      x       = m_busy && req[g] && !fifo_full;
      e_grant = m_busy ? N'(1 << g) : '0;
      e_ready = x ? N'(1 << g) : '0;
      e_data  = req_data[g*DW +: DW];
      s_grant = grant; s_ready = req_ready; s_data = fifo_w_data;
      s_idx   = grant_idx; s_wen = fifo_w_en; s_busy = busy;
      chk("cycle outputs", {busy, grant_idx, grant, req_ready, fifo_w_en, fifo_w_data},
          {m_busy, 2'(m_g), e_grant, e_ready, x, e_data});
      if (!m_busy) begin
         w = pick(m_rr, req);
         if (w >= 0) begin
            m_busy = 1'b1; m_g = w; m_rr = w; m_words = 0;
         end
      end else begin
         done  = m_words + (x ? 1 : 0);
         ended = !req[g] || (x && (req_last[g] || done == MB));
         if (ended) begin
            w = pick(m_rr, req);
            if (w >= 0) begin
               m_g = w; m_rr = w; m_words = 0;
            end else begin
               m_busy = 1'b0;
            end
         end else begin
            m_words = done;
         end
      end
      @(posedge w_clk);
      #1;
   endtask

   task automatic do_reset();
      w_rst_n   = 1'b0;
      req       = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      repeat (2) @(posedge w_clk);
      #1;
      chk("reset outputs", {busy, grant_idx, grant, req_ready, fifo_w_en}, '0);
      w_rst_n = 1'b1;
      m_reset();
   endtask

   task automatic words_rr();
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(i * 4 + sent[i] % 4);
   endtask

   task automatic advance_sent();
      for (int i = 0; i < N; i++) if (s_ready[i]) sent[i]++;
   endtask

   initial begin
      int first, lastw, wcnt, fcnt;

      // Requester words: 0 -> A, 1 -> B, 2 -> C, 3 -> D
      tbl[0]  = '{4'b0100, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'hA, 1'b0};
      tbl[1]  = '{4'b1100, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0100, 4'hC, 1'b1};
      tbl[2]  = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b1000, 4'hD, 1'b1};
      tbl[3]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 4'b0000, 4'hD, 1'b1};
      tbl[4]  = '{4'b0001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 4'b0000, 4'hD, 1'b1};
      tbl[5]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0001, 4'hA, 1'b1};
      tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000, 4'hA, 1'b1};
      tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'hA, 1'b0};
      tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 4'b0000, 4'hB, 1'b1};
      tbl[9]  = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0100, 4'hC, 1'b1};
      tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0000, 4'hC, 1'b1};
      tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 4'b0000, 4'hC, 1'b0};

      do_reset();
      req_data = 16'hDCBA;
      for (int i = 0; i < 12; i++) begin
         req       = tbl[i].req;
         req_last  = tbl[i].last;
         fifo_full = tbl[i].full;
         @(negedge w_clk);
         chk($sformatf("table row %0d", i),
             {busy, grant_idx, grant, req_ready, fifo_w_en, fifo_w_data},
             {tbl[i].busy, tbl[i].idx, tbl[i].grant, tbl[i].ready, tbl[i].wen, tbl[i].data});
         @(posedge w_clk);
         #1;
      end

      // Reset in the middle of a burst releases immediately, then full round-robin rotation
      do_reset();
      sent = '{default: 0};
      words_rr();
      req = 4'b1111;
      repeat (3) begin
         cycle();
         advance_sent();
         words_rr();
      end
      w_rst_n = 1'b0;
      #1;
      chk("async reset grant", 32'(grant), 32'(0));
      chk("async reset wen", 32'(fifo_w_en), 32'(0));
      @(posedge w_clk);
      #1;
      w_rst_n = 1'b1;
      m_reset();
      sent = '{default: 0};
      words_rr();
      cycle();
      for (int n = 0; n < 16; n++) begin
         cycle();
         chk("rotation wen", 32'(s_wen), 32'(1));
         chk("rotation data", 32'(s_data), 32'(n));
         chk("rotation idx", 32'(s_idx), 32'(n / 4));
         advance_sent();
         words_rr();
      end
      cycle();
      chk("rotation wrap grant", 32'(s_grant), 32'(4'b0001));

      // Single requester, 6-word packet split by the burst limit
      do_reset();
      sent = '{default: 0};
      first = -1; lastw = -1; wcnt = 0;
      for (int n = 0; n < 12; n++) begin
         req[1]        = (sent[1] < 6);
         req_last[1]   = (sent[1] == 5);
         req_data[7:4] = DW'(sent[1] + 1);
         cycle();
         if (s_wen) begin
            wcnt++;
            chk("packet data", 32'(s_data), 32'(wcnt));
            if (first < 0) first = n;
            lastw = n;
         end
         advance_sent();
      end
      chk("packet writes", 32'(wcnt), 32'(6));
      chk("packet no gap", 32'(lastw - first), 32'(5));
      chk("packet idle", {busy, grant}, '0);

      // FIFO full stalls a burst after its second word
      do_reset();
      sent = '{default: 0};
      fcnt = 0; wcnt = 0;
      for (int n = 0; n < 14; n++) begin
         req[2]          = (sent[2] < 4);
         req_last[2]     = (sent[2] == 3);
         req_data[11:8]  = DW'(sent[2] + 5);
         fifo_full       = (sent[2] == 2) && (fcnt < 3);
         cycle();
         if (fifo_full) begin
            fcnt++;
            chk("stall outputs", {s_wen, s_ready}, '0);
         end
         if (s_wen) wcnt++;
         advance_sent();
      end
      fifo_full = 1'b0;
      chk("stall writes", 32'(wcnt), 32'(4));
      chk("stall cycles", 32'(fcnt), 32'(3));

      // Random traffic obeying the hold-while-waiting rule
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         fifo_full = ($urandom_range(3) == 0);
         cycle();
         for (int i = 0; i < N; i++) begin
            if (req[i] && s_ready[i]) begin
               if ($urandom_range(3) == 0) begin
                  req[i] = 1'b0;
               end else begin
                  req_data[i*DW +: DW] = DW'($urandom);
                  req_last[i]          = ($urandom_range(3) == 0);
               end
            end else if (req[i]) begin
               if ($urandom_range(15) == 0) req[i] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               req[i]               = 1'b1;
               req_data[i*DW +: DW] = DW'($urandom);
               req_last[i]          = ($urandom_range(3) == 0);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
`default_nettype wire
